fifo_ctrl_sc: RTL and testbench

//   Single-clock FIFO controller that sequences an external simple dual-port RAM (registered read,
//   1-cycle latency, write and read clocks both tied to i_clk). It owns the read/write pointers,

---
 rtl/fifo_ctrl_sc.sv | 66 ++++++
 tb/tb_fifo_ctrl_sc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_sc.sv
// fifo_ctrl_sc: single-clock FIFO controller sequencing an external 1-cycle-latency dual-port RAM
module fifo_ctrl_sc #(
  parameter int SIZE_DEPTH = 16,
  parameter int SIZE_ADDR  = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_wr_req,
  input  logic                 i_rd_req,
  output logic                 o_mem_wr_en,
  output logic [SIZE_ADDR-1:0] o_mem_addr_wr,
  output logic                 o_mem_rd_en,
  output logic [SIZE_ADDR-1:0] o_mem_addr_rd,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_ovf,
  output logic                 o_udf
);
  localparam logic [SIZE_ADDR:0] DEPTH = (SIZE_ADDR+1)'(SIZE_DEPTH);
  localparam logic [SIZE_ADDR:0] AF_TH = (SIZE_ADDR+1)'(SIZE_DEPTH - AF_MARGIN);
  localparam logic [SIZE_ADDR:0] AE_TH = (SIZE_ADDR+1)'(AE_MARGIN);
  logic [SIZE_ADDR:0] wptr, rptr, count;
  logic wr_acc, rd_acc;
  assign o_full         = count == DEPTH;
  assign o_empty        = count == '0;
  assign o_almost_full  = count >= AF_TH;
  assign o_almost_empty = count <= AE_TH;
  assign o_count        = count;
  assign wr_acc         = i_wr_req & ~o_full & ~i_clr;
  assign rd_acc         = i_rd_req & ~o_empty & ~i_clr;
  assign o_mem_wr_en    = wr_acc;
  assign o_mem_rd_en    = rd_acc;
  assign o_mem_addr_wr  = wptr[SIZE_ADDR-1:0];
  assign o_mem_addr_rd  = rptr[SIZE_ADDR-1:0];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_rd_valid <= 1'b0;
      o_ovf      <= 1'b0;
      o_udf      <= 1'b0;
    end else if (i_clr) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_rd_valid <= 1'b0;
      o_ovf      <= 1'b0;
      o_udf      <= 1'b0;
    end else begin
      wptr       <= wptr + {{SIZE_ADDR{1'b0}}, wr_acc};
      rptr       <= rptr + {{SIZE_ADDR{1'b0}}, rd_acc};
      count      <= count + {{SIZE_ADDR{1'b0}}, wr_acc} - {{SIZE_ADDR{1'b0}}, rd_acc};
      o_rd_valid <= rd_acc;
      o_ovf      <= o_ovf | (i_wr_req & o_full);
      o_udf      <= o_udf | (i_rd_req & o_empty);
    end
  end
endmodule

// File: tb/tb_fifo_ctrl_sc.sv
// tb_fifo_ctrl_sc: directed scenario tasks against hand-computed FIFO controller expectations
module tb_fifo_ctrl_sc;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic wr_en, rd_en, rd_valid, full, empty, afull, aempty, ovf, udf;
  logic [3:0] addr_wr, addr_rd;
  logic [4:0] count;
  int pass = 0, total = 0;
  logic [7:0] ram [16];
  logic [7:0] wdata = '0, rdata;
  fifo_ctrl_sc dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_req(wr_req), .i_rd_req(rd_req),
    .o_mem_wr_en(wr_en), .o_mem_addr_wr(addr_wr), .o_mem_rd_en(rd_en), .o_mem_addr_rd(addr_rd),
    .o_rd_valid(rd_valid), .o_full(full), .o_empty(empty), .o_almost_full(afull),
    .o_almost_empty(aempty), .o_count(count), .o_ovf(ovf), .o_udf(udf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (wr_en) ram[addr_wr] <= wdata;
    if (rd_en) rdata <= ram[addr_rd];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  task automatic test_reset();
    #12;
    total++; if ({count, empty, aempty, full, afull, rd_valid, ovf, udf} !== {5'd0, 7'b1100000})
      $display("FAIL reset: count=%0d e=%b ae=%b f=%b af=%b v=%b ovf=%b udf=%b", count, empty, aempty, full, afull, rd_valid, ovf, udf);
    else pass++;
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_req = 1'b1;
      #1;
      total++; if (wr_en !== 1'b1 || addr_wr !== 4'(i)) $display("FAIL fill_wr[%0d]: wr_en=%b addr=%0d expected 1/%0d", i, wr_en, addr_wr, i); else pass++;
      step();
      total++; if (count !== 5'(i + 1) || afull !== (i + 1 >= 14) || full !== (i + 1 == 16) || rd_valid !== 1'b0)
        $display("FAIL fill_state[%0d]: count=%0d af=%b f=%b v=%b", i, count, afull, full, rd_valid);
      else pass++;
    end
    wr_req = 1'b0;
  endtask
  task automatic test_ovf();
    wr_req = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0) $display("FAIL ovf_wr_en: got %b expected 0", wr_en); else pass++;
    step();
    wr_req = 1'b0;
    total++; if (ovf !== 1'b1 || count !== 5'd16) $display("FAIL ovf_set: ovf=%b count=%0d expected 1/16", ovf, count); else pass++;
    step();
    total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf); else pass++;
  endtask
  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_req = 1'b1;
      #1;
      total++; if (rd_en !== 1'b1 || addr_rd !== 4'(i)) $display("FAIL drain_rd[%0d]: rd_en=%b addr=%0d expected 1/%0d", i, rd_en, addr_rd, i); else pass++;
      step();
      total++; if (rd_valid !== 1'b1 || count !== 5'(15 - i)) $display("FAIL drain_state[%0d]: v=%b count=%0d expected 1/%0d", i, rd_valid, count, 15 - i); else pass++;
    end
    rd_req = 1'b0;
    #1;
    total++; if (empty !== 1'b1 || aempty !== 1'b1 || udf !== 1'b0) $display("FAIL drain_empty: e=%b ae=%b udf=%b", empty, aempty, udf); else pass++;
    step();
    total++; if (rd_valid !== 1'b0) $display("FAIL drain_valid_off: got %b expected 0", rd_valid); else pass++;
  endtask
  task automatic test_simul();
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    total++; if (wr_en !== 1'b1 || rd_en !== 1'b0) $display("FAIL simul_empty_en: wr=%b rd=%b expected 1/0", wr_en, rd_en); else pass++;
    step();
    total++; if (udf !== 1'b1 || count !== 5'd1 || rd_valid !== 1'b0) $display("FAIL simul_empty_state: udf=%b count=%0d v=%b", udf, count, rd_valid); else pass++;
    #1;
    total++; if (wr_en !== 1'b1 || rd_en !== 1'b1 || addr_wr !== 4'd1 || addr_rd !== 4'd0)
      $display("FAIL simul_both_en: wr=%b rd=%b aw=%0d ar=%0d expected 1/1/1/0", wr_en, rd_en, addr_wr, addr_rd);
    else pass++;
    step();
    wr_req = 1'b0;
    rd_req = 1'b0;
    total++; if (count !== 5'd1 || rd_valid !== 1'b1) $display("FAIL simul_both_state: count=%0d v=%b expected 1/1", count, rd_valid); else pass++;
  endtask
  task automatic test_wrap();
    logic [4:0] mw = '0, mr = '0;
    int mc = 0, wn = 0, rn = 0, vn = 0, k = 0;
    logic wa, ra, pra = 1'b0;
    do_clr();
    total++; if (count !== 5'd0 || udf !== 1'b0 || ovf !== 1'b0) $display("FAIL wrap_clr: count=%0d udf=%b ovf=%b", count, udf, ovf); else pass++;
    while (vn < 24 && k < 200) begin
      wr_req = (wn < 24) && (k % 4 != 3);
      rd_req = (rn < 24) && (k >= 3) && (k % 3 != 0);
      wa = wr_req && mc != 16;
      ra = rd_req && mc != 0;
      wdata = 8'(wn);
      #1;
      total++; if (wr_en !== wa || rd_en !== ra || (wa && addr_wr !== mw[3:0]) || (ra && addr_rd !== mr[3:0]))
        $display("FAIL wrap_en[%0d]: wr=%b aw=%0d rd=%b ar=%0d expected %b/%0d %b/%0d", k, wr_en, addr_wr, rd_en, addr_rd, wa, mw[3:0], ra, mr[3:0]);
      else pass++;
      mw += 5'(wa);
      mr += 5'(ra);
      mc += int'(wa) - int'(ra);
      wn += int'(wa);
      rn += int'(ra);
      pra = ra;
      step();
      total++; if (count !== 5'(mc) || count > 5'd16 || rd_valid !== pra) $display("FAIL wrap_state[%0d]: count=%0d v=%b expected %0d/%b", k, count, rd_valid, mc, pra); else pass++;
      if (rd_valid) begin
        total++; if (rdata !== 8'(vn)) $display("FAIL wrap_order[%0d]: data=%0d expected %0d", vn, rdata, vn); else pass++;
        vn++;
      end
      k++;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    total++; if (vn != 24 || mw != 5'd24) $display("FAIL wrap_timeout: reads=%0d writes=%0d expected 24/24", vn, mw); else pass++;
  endtask
  task automatic test_full_both();
    do_clr();
    wr_req = 1'b1;
    repeat (16) step();
    rd_req = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0 || rd_en !== 1'b1 || addr_rd !== 4'd0) $display("FAIL full_both_en: wr=%b rd=%b ar=%0d expected 0/1/0", wr_en, rd_en, addr_rd); else pass++;
    step();
    wr_req = 1'b0;
    rd_req = 1'b0;
    total++; if (ovf !== 1'b1 || count !== 5'd15 || full !== 1'b0 || afull !== 1'b1) $display("FAIL full_both_state: ovf=%b count=%0d f=%b af=%b", ovf, count, full, afull); else pass++;
  endtask
  task automatic test_clr_reset();
    do_clr();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    wr_req = 1'b1;
    repeat (5) step();
    wr_req = 1'b0;
    total++; if (count !== 5'd5 || udf !== 1'b1 || aempty !== 1'b0) $display("FAIL clr_pre: count=%0d udf=%b ae=%b expected 5/1/0", count, udf, aempty); else pass++;
    clr = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) $display("FAIL clr_priority: wr=%b rd=%b expected 0/0", wr_en, rd_en); else pass++;
    step();
    clr = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    total++; if (count !== 5'd0 || empty !== 1'b1 || udf !== 1'b0 || ovf !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL clr_state: count=%0d e=%b udf=%b ovf=%b v=%b", count, empty, udf, ovf, rd_valid);
    else pass++;
    wr_req = 1'b1;
    repeat (2) step();
    wr_req = 1'b0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    total++; if (rd_valid !== 1'b1 || count !== 5'd1) $display("FAIL rst_pre: v=%b count=%0d expected 1/1", rd_valid, count); else pass++;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) $display("FAIL rst_async: v=%b count=%0d e=%b expected 0/0/1", rd_valid, count, empty); else pass++;
    #1;
    rst_n = 1'b1;
    step();
  endtask
  initial begin
    test_reset();
    test_fill();
    test_ovf();
    test_drain();
    test_simul();
    test_wrap();
    test_full_both();
    test_clr_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
